fu_issue_ctrl: RTL

Initiator side of the functional-unit EN/finish protocol. Accepts operand pairs from the issue stage over valid/ready and launches each on a multi-cycle FU (e.g. the 7-stage multiplier unit) with a one-cycle EN pulse. Holds operands stable until the FU's one-cycle finish pulse, captures the result, and queues it with its tag for write-back. One op in flight at a time; a watchdog flags a lost finish.

---
 rtl/fu_issue_ctrl_if.sv | 50 +++++
 rtl/fu_issue_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fu_issue_ctrl_if.sv
// ============================================================================
// Module   : fu_issue_ctrl_if
// Brief    : Issue, FU EN/finish and write-back buses of the FU issue controller
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [TAG_W-1:0]  issue_tag;

  logic              fu_en;
  logic [DATA_W-1:0] fu_a;
  logic [DATA_W-1:0] fu_b;
  logic [DATA_W-1:0] fu_res;
  logic              fu_finish;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  wb_tag;

  // The controller side
  modport master (
    input  issue_valid, issue_a, issue_b, issue_tag,
    output issue_ready,
    output fu_en, fu_a, fu_b,
    input  fu_res, fu_finish,
    output wb_valid, wb_data, wb_tag,
    input  wb_ready
  );

  // Issue stage, functional unit and write-back consumer
  modport slave (
    output issue_valid, issue_a, issue_b, issue_tag,
    input  issue_ready,
    input  fu_en, fu_a, fu_b,
    output fu_res, fu_finish,
    input  wb_valid, wb_data, wb_tag,
    output wb_ready
  );
endinterface

`default_nettype wire

// File: rtl/fu_issue_ctrl.sv
// ============================================================================
// Module   : fu_issue_ctrl
// Brief    : Launches one op at a time on a multi-cycle FU via EN/finish and
//            queues tagged results for write-back; watchdog flags lost finish.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fu_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 5,
  parameter int MAX_LAT  = 16,
  parameter int WB_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  fu_issue_ctrl_if.master bus,
  output logic            busy,
  output logic            timeout
);

  localparam int c_CNT_W  = $clog2(MAX_LAT + 1);
  localparam int c_PTR_W  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int c_FILL_W = $clog2(WB_DEPTH + 1);
  localparam int c_ENT_W  = TAG_W + DATA_W;

  localparam logic [c_CNT_W-1:0]  c_LAT      = c_CNT_W'(MAX_LAT);
  localparam logic [c_CNT_W-1:0]  c_LAT_M1   = c_CNT_W'(MAX_LAT - 1);
  localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(WB_DEPTH - 1);
  localparam logic [c_FILL_W-1:0] c_FULL     = c_FILL_W'(WB_DEPTH);

  typedef enum logic [1:0] {
    S_DRAIN = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;

  logic [DATA_W-1:0]  r_fu_a;
  logic [DATA_W-1:0]  r_fu_b;
  logic [TAG_W-1:0]   r_tag;
  logic               r_timeout;

  logic [c_ENT_W-1:0]  r_mem [WB_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_FILL_W-1:0] r_fill;

  logic w_room;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_timeout_set;

  assign w_room   = (r_fill < c_FULL);
  assign w_accept = (r_state == S_IDLE) && bus.issue_valid && w_room;
  assign w_pop    = (r_fill != '0) && bus.wb_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_push        = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      // Lets an FU launched before reset run out before the next EN
      S_DRAIN: begin
        if (r_cnt == c_LAT_M1) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = {{(c_CNT_W-1){1'b0}}, 1'b1};
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // A finish in the last watchdog cycle still counts as on time
        if (bus.fu_finish) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_LAT) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
        end
      end
      default: begin
        w_state_nxt = S_DRAIN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_DRAIN;
      r_cnt     <= '0;
      r_fu_a    <= '0;
      r_fu_b    <= '0;
      r_tag     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_fu_a <= bus.issue_a;
        r_fu_b <= bus.issue_b;
        r_tag  <= bus.issue_tag;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Space is reserved at accept time, so a push never meets a full FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_tag, bus.fu_res};
    end
  end

  assign bus.issue_ready = (r_state == S_IDLE) && w_room;
  assign bus.fu_en       = (r_state == S_ISSUE);
  assign bus.fu_a        = r_fu_a;
  assign bus.fu_b        = r_fu_b;
  assign bus.wb_valid    = (r_fill != '0);
  assign bus.wb_data     = r_mem[r_rd_ptr][DATA_W-1:0];
  assign bus.wb_tag      = r_mem[r_rd_ptr][c_ENT_W-1:DATA_W];
  assign busy            = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign timeout         = r_timeout;

endmodule

`default_nettype wire
